// File: rtl/register_pkg.sv
// ============================================================================
// Module      : register_pkg
// Description : Shared width default and even-parity helper for register.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package register_pkg;

  localparam int DEFAULT_WIDTH = 12;

  // Zero-extension to 64 bits leaves the parity of any narrower word unchanged.
  function automatic logic even_parity(input logic [63:0] data);
    return ^data;
  endfunction

endpackage

`default_nettype wire

// File: rtl/register_parity.sv
// ============================================================================
// Module      : register_parity
// Description : Even-parity generation for incoming data and check of stored data.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module register_parity
  import register_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] data_i,
  input  logic [WIDTH-1:0] stored_data_i,
  input  logic             stored_parity_i,
  output logic             parity_o,
  output logic             mismatch_o
);

  logic [63:0] w_data_ext;
  logic [63:0] w_stored_ext;

  always_comb begin
    w_data_ext               = '0;
    w_data_ext[WIDTH-1:0]    = data_i;
    w_stored_ext             = '0;
    w_stored_ext[WIDTH-1:0]  = stored_data_i;
  end

  assign parity_o   = even_parity(w_data_ext);
  assign mismatch_o = even_parity(w_stored_ext) ^ stored_parity_i;

endmodule

`default_nettype wire

// File: rtl/register.sv
// ============================================================================
// Module      : register
// Description : WIDTH-bit load-enabled register with async reset; optional
//               parity protection compiled in by REGISTER_PARITY_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module register
  import register_pkg::*;
#(
  parameter int               WIDTH       = DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clock,
  input  logic             rst,
  input  logic             writeEn,
  input  logic [WIDTH-1:0] dataIn,
`ifdef REGISTER_PARITY_EN
  output logic             parityErr,
`endif
  output logic [WIDTH-1:0] dataOut
);

  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_d;

  // Ternary keeps an unknown writeEn visible instead of silently holding.
  assign data_d  = writeEn ? dataIn : data_q;
  assign dataOut = data_q;

`ifdef REGISTER_PARITY_EN
  localparam logic RESET_PARITY = ^RESET_VALUE;

  logic parity_q;
  logic parity_d;
  logic parity_err_q;
  logic parity_err_d;
  logic w_gen_parity;
  logic w_mismatch;

  register_parity #(
    .WIDTH (WIDTH)
  ) u_parity (
    .data_i          (dataIn),
    .stored_data_i   (data_q),
    .stored_parity_i (parity_q),
    .parity_o        (w_gen_parity),
    .mismatch_o      (w_mismatch)
  );

  assign parity_d     = writeEn ? w_gen_parity : parity_q;
  assign parity_err_d = parity_err_q | w_mismatch;
  assign parityErr    = parity_err_q;

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      data_q       <= RESET_VALUE;
      parity_q     <= RESET_PARITY;
      parity_err_q <= 1'b0;
    end else begin
      data_q       <= data_d;
      parity_q     <= parity_d;
      parity_err_q <= parity_err_d;
    end
  end
`else
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      data_q <= RESET_VALUE;
    end else begin
      data_q <= data_d;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_register.sv
// ============================================================================
// Module      : tb_register
// Description : Directed self-checking bench for register (REGISTER_PARITY_EN
//               adds the parity scenario).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_register;
  import register_pkg::*;

  localparam int W = 12;

  logic         clock;
  logic         rst;
  logic         writeEn;
  logic [W-1:0] dataIn;
  logic [W-1:0] dataOut;
`ifdef REGISTER_PARITY_EN
  logic         parityErr;
`endif

  int total = 0;
  int bad   = 0;

  register #(
    .WIDTH       (W),
    .RESET_VALUE ('0)
  ) dut (
    .clock     (clock),
    .rst       (rst),
    .writeEn   (writeEn),
    .dataIn    (dataIn),
`ifdef REGISTER_PARITY_EN
    .parityErr (parityErr),
`endif
    .dataOut   (dataOut)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  logic [W-1:0] b2b_vec [4] = '{12'h001, 12'h800, 12'h5A5, 12'hA5A};
  logic [W-1:0] hold_vec [2] = '{12'h000, 12'hFFF};

  initial begin
    rst = 1'b1; writeEn = 1'b0; dataIn = 12'h123;
    #10; check_val("reset", dataOut, 12'h000);                 // t=10
`ifdef REGISTER_PARITY_EN
    check_val("reset_perr", parityErr, 1'b0);
`endif
    rst = 1'b0; writeEn = 1'b1; dataIn = 12'h456;
    #10; check_val("write", dataOut, 12'h456);                 // t=20
    writeEn = 1'b0; dataIn = 12'h789;
    #10; check_val("hold", dataOut, 12'h456);                  // t=30
    #2 dataIn = 12'hABC;
    #2 check_val("no_comb_path", dataOut, 12'h456);            // t=34
    #2 rst = 1'b1;
    #1 check_val("async_rst", dataOut, 12'h000);               // t=37
    #1 rst = 1'b0;
    #1 check_val("async_rst_kept", dataOut, 12'h000);          // t=39
    #1 writeEn = 1'b1; dataIn = 12'hABC;                       // t=40
    #10; check_val("write_after_rst", dataOut, 12'hABC);       // t=50
    rst = 1'b1; dataIn = 12'hFFF;
    #10; check_val("rst_vs_write", dataOut, 12'h000);          // t=60
    rst = 1'b0;
    #10; check_val("first_edge_after_rst", dataOut, 12'hFFF);  // t=70
    for (int i = 0; i < 4; i++) begin
      dataIn = b2b_vec[i];
      #10; check_val("back_to_back", dataOut, b2b_vec[i]);     // t=80..110
    end
    dataIn = 12'h111;
    #3 dataIn = 12'h222;
    #1 check_val("mid_cycle_change", dataOut, 12'hA5A);        // t=114
    #6 check_val("last_value_wins", dataOut, 12'h222);         // t=120
    writeEn = 1'b0;
    for (int i = 0; i < 2; i++) begin
      dataIn = hold_vec[i];
      #10; check_val("hold_vs_data", dataOut, 12'h222);        // t=130,140
    end
`ifdef REGISTER_PARITY_EN
    check_val("perr_quiet", parityErr, 1'b0);
    writeEn = 1'b1; dataIn = 12'h456;
    #10; check_val("par_write", dataOut, 12'h456);             // t=150
    check_val("par_write_perr", parityErr, 1'b0);
    writeEn = 1'b0;
    force dut.parity_q = ~even_parity(64'h456);
    #10; check_val("par_flip", parityErr, 1'b1);               // t=160
    #10; check_val("par_sticky", parityErr, 1'b1);             // t=170
    #1 rst = 1'b1;
    #1 check_val("par_rst_clear", parityErr, 1'b0);            // t=172
    release dut.parity_q;
    #5 rst = 1'b0;                                             // t=177, reset edge at 175
    #3 check_val("par_after_rst", parityErr, 1'b0);            // t=180
    check_val("par_after_rst_data", dataOut, 12'h000);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/register.md
REGISTER -- requirements
Module: register

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset: clock and rst.
REQ-002 Parameter WIDTH SHALL default to 12 and set the data width in bits; legal range 1..64.
REQ-003 Parameter RESET_VALUE SHALL default to all zeros, be WIDTH bits wide, and set the value loaded on reset.
REQ-004 Port clock SHALL be an input, 1 bit, the system clock; all state changes on its rising edge.
REQ-005 Port rst SHALL be an input, 1 bit, the asynchronous active-high reset.
REQ-006 Port writeEn SHALL be an input, 1 bit, the load enable.
REQ-007 Port dataIn SHALL be an input, WIDTH bits, the data to load.
REQ-008 Port dataOut SHALL be an output, WIDTH bits, the stored value, driven directly from a flop.
REQ-009 With REGISTER_PARITY_EN defined, port parityErr SHALL be an output, 1 bit, the stored-parity mismatch flag.

Function
REQ-010 On a rising clock edge with rst=0 and writeEn=1, dataOut SHALL take dataIn; latency 1 edge.
REQ-011 On a rising clock edge with rst=0 and writeEn=0, dataOut SHALL hold its value, whatever dataIn is.
REQ-012 dataIn SHALL never reach dataOut combinationally; changes between edges SHALL have no effect.
REQ-013 An X or Z on writeEn SHALL NOT be masked; no special handling is required.
REQ-014 writeEn held high over consecutive edges SHALL load every cycle; back-to-back writes need no idle cycle.

Reset
REQ-015 rst=1 SHALL force dataOut to RESET_VALUE immediately, without waiting for a clock edge.
REQ-016 While rst=1, writeEn and dataIn SHALL be ignored.
REQ-017 If rst is asserted during a write cycle, reset SHALL win.
REQ-018 After rst deasserts, the first rising edge SHALL follow REQ-010/011 normally.
REQ-019 With REGISTER_PARITY_EN defined, reset SHALL load parity consistent with RESET_VALUE and clear parityErr to 0.

Configuration
REQ-020 Macro REGISTER_PARITY_EN SHALL compile in parity protection. The block SHALL store an even-parity bit of dataIn on each write. parityErr SHALL be a registered flag, set one cycle after the stored data and stored parity disagree, and held until reset.
REQ-021 Without REGISTER_PARITY_EN, the parity flop and the parityErr port SHALL be absent, and the behaviour SHALL be exactly REQ-010 to REQ-018.

Structure
REQ-022 A shared package register_pkg SHALL hold the default width constant (12) and the parity function used by the design and the bench.
REQ-023 One sub-module, register_parity, SHALL be natural: WIDTH-bit even-parity generation and checking, instantiated only under REGISTER_PARITY_EN.
REQ-024 Storage SHALL be one always block on the rising edge of clock and of rst; no latches, no gated clocks.

Verification
Stimulus for every scenario is applied between edges, with a clock period of 10 ns and the first rising edge at 5 ns.
REQ-025 Reset scenario: rst=1, writeEn=0, dataIn=0x123 held for 10 ns -> dataOut=0x000 at 10 ns.
REQ-026 Write scenario: rst=0, writeEn=1, dataIn=0x456 -> dataOut=0x456 after the next edge (checked at 20 ns).
REQ-027 Hold scenario: rst=0, writeEn=0, dataIn=0x789 -> dataOut stays 0x456 (checked at 30 ns).
REQ-028 Asynchronous reset scenario: with dataOut=0x456, pulse rst high for 2 ns between edges -> dataOut=0x000 before the next edge; a later write of 0xABC -> dataOut=0xABC.
REQ-029 Reset-versus-write scenario: rst=1 and writeEn=1 with dataIn=0xFFF across an edge -> dataOut=0x000.
REQ-030 Parity scenario (REGISTER_PARITY_EN defined): write 0x456 -> parityErr=0; force-flip the stored parity bit -> parityErr=1 one edge later; assert rst -> parityErr=0.
